// File: rtl/prom_pkg.sv
// Shared constants and state type for the bipolar PROM scanner.
package prom_pkg;

    localparam int unsigned PROM_DEPTH = 32;
    localparam int unsigned PROM_AW    = 5;
    localparam int unsigned PROM_DW    = 8;

    // Open-collector bus with pull-ups reads all ones when the PROM is deselected.
    localparam logic [PROM_DW-1:0] PROM_FLOAT = 8'hFF;

    typedef enum logic [1:0] {IDLE, FLOAT, ACCESS, DONE} prom_scan_state_t;

endpackage

// File: rtl/prom_scan_if.sv
// Control, status, PROM socket and shadow read signals of the PROM scanner.
interface prom_scan_if;
    import prom_pkg::*;

    logic               start;
    logic [PROM_DW-1:0] exp_sum;
    logic               busy;
    logic               done;
    logic               img_valid;
    logic [PROM_DW-1:0] sum;
    logic               sum_ok;
    logic               bus_err;
    logic [PROM_AW-1:0] prom_a;
    logic               prom_ce_n;
    logic [PROM_DW-1:0] prom_d;
    logic [PROM_AW-1:0] rd_addr;
    logic [PROM_DW-1:0] rd_data;

    modport master (
        output start, exp_sum, prom_d, rd_addr,
        input  busy, done, img_valid, sum, sum_ok, bus_err, prom_a, prom_ce_n, rd_data
    );

    modport slave (
        input  start, exp_sum, prom_d, rd_addr,
        output busy, done, img_valid, sum, sum_ok, bus_err, prom_a, prom_ce_n, rd_data
    );

endinterface

// File: rtl/prom_shadow.sv
// 32x8 shadow copy of the PROM image; written only by scan captures.
module prom_shadow
    import prom_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [PROM_AW-1:0] waddr,
    input  logic [PROM_DW-1:0] wdata,
    input  logic [PROM_AW-1:0] raddr,
    output logic [PROM_DW-1:0] rdata
);

    logic [PROM_DW-1:0] mem [PROM_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PROM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prom_scan.sv
// PROM scan initiator: float check, 32 timed byte reads into the shadow bank,
// and a running 8-bit modular checksum.
module prom_scan
    import prom_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input logic       clk,
    input logic       reset,
    prom_scan_if.slave bus
);

    localparam int unsigned CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE);
    localparam logic [PROM_AW-1:0] ADDR_LAST = PROM_AW'(PROM_DEPTH - 1);

    prom_scan_state_t   state;
    logic [CW-1:0]      cnt;
    logic [PROM_AW-1:0] addr;
    logic [PROM_DW-1:0] sum_q;
    logic               busy_q;
    logic               done_q;
    logic               ce_n_q;
    logic               img_valid_q;
    logic               bus_err_q;
    logic               cap;

    assign cap = (state == ACCESS) && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            addr        <= '0;
            sum_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ce_n_q      <= 1'b1;
            img_valid_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= FLOAT;
                        cnt         <= '0;
                        sum_q       <= '0;
                        img_valid_q <= 1'b0;
                        bus_err_q   <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                FLOAT: begin
                    if (cnt == CNT_MAX) begin
                        if (bus.prom_d != PROM_FLOAT) bus_err_q <= 1'b1;
                        state  <= ACCESS;
                        cnt    <= '0;
                        addr   <= '0;
                        ce_n_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_MAX) begin
                        sum_q <= sum_q + bus.prom_d;
                        cnt   <= '0;
                        // Address returns to 0 on the final capture so IDLE drives 0.
                        if (addr == ADDR_LAST) begin
                            state  <= DONE;
                            addr   <= '0;
                            ce_n_q <= 1'b1;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    img_valid_q <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    prom_shadow u_shadow (
        .clk   (clk),
        .reset (reset),
        .we    (cap),
        .waddr (addr),
        .wdata (bus.prom_d),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.img_valid = img_valid_q;
    assign bus.sum       = sum_q;
    assign bus.sum_ok    = img_valid_q && (sum_q == bus.exp_sum);
    assign bus.bus_err   = bus_err_q;
    assign bus.prom_a    = addr;
    assign bus.prom_ce_n = ce_n_q;

endmodule

// File: tb/tb_prom_scan.sv
// Self-checking bench for prom_scan: PROM socket model plus an image/checksum reference.
module tb_prom_scan;
    import prom_pkg::*;

    localparam int unsigned S2 = 2;
    localparam int unsigned S4 = 4;
    localparam int LAT2 = 1 + 33 * (S2 + 1);
    localparam int LAT4 = 1 + 33 * (S4 + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prom_scan_if bus2 ();
    prom_scan_if bus4 ();

    prom_scan #(.SETTLE(S2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    prom_scan #(.SETTLE(S4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    logic [7:0] rom [32];
    bit         float_bad;
    int         n_cmp;
    int         n_bad;

    // PROM socket: image byte while selected, pulled-up float (or a stuck bus) otherwise.
    assign bus2.prom_d = bus2.prom_ce_n ? (float_bad ? 8'h7F : 8'hFF) : rom[bus2.prom_a];
    assign bus4.prom_d = bus4.prom_ce_n ? (float_bad ? 8'h7F : 8'hFF) : rom[bus4.prom_a];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 32; i++) rom[i] = 8'(i);
    endtask

    task automatic load_random();
        for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
    endtask

    function automatic logic [7:0] model_sum();
        int t = 0;
        for (int i = 0; i < 32; i++) t += int'(rom[i]);
        return 8'(t % 256);
    endfunction

    // Start a scan on dut2 and watch for done; extra start pulses in cycles ign1/ign2.
    task automatic run_scan2(input int ign1, input int ign2, output int first_done,
                             output int pulses, output logic busy_at_done);
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        first_done   = -1;
        pulses       = 0;
        busy_at_done = 1'bx;
        for (int n = 1; n <= LAT2 + 40; n++) begin
            bus2.start = (n == ign1) || (n == ign2);
            tick();
            bus2.start = 1'b0;
            if (bus2.done) begin
                pulses++;
                if (first_done < 0) begin
                    first_done   = n + 1;
                    busy_at_done = bus2.busy;
                end
            end
        end
    endtask

    task automatic check_image(input string name);
        for (int k = 0; k < 32; k++) begin
            bus2.rd_addr = 5'(k);
            #1;
            n_cmp++;
            if (bus2.rd_data !== rom[k]) begin
                n_bad++;
                $display("FAIL %s shadow[%0d]: got %02h want %02h", name, k, bus2.rd_data, rom[k]);
            end
        end
    endtask

    task automatic test_reset();
        bus2.start = 1'b0; bus2.exp_sum = 8'h00; bus2.rd_addr = '0;
        bus4.start = 1'b0; bus4.exp_sum = 8'h00; bus4.rd_addr = '0;
        float_bad = 1'b0;
        load_ramp();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (bus2.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", bus2.busy); end
        n_cmp++; if (bus2.done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", bus2.done); end
        n_cmp++; if (bus2.img_valid !== 1'b0) begin n_bad++; $display("FAIL reset img_valid: got %b want 0", bus2.img_valid); end
        n_cmp++; if (bus2.sum !== 8'h00) begin n_bad++; $display("FAIL reset sum: got %02h want 00", bus2.sum); end
        n_cmp++; if (bus2.sum_ok !== 1'b0) begin n_bad++; $display("FAIL reset sum_ok: got %b want 0", bus2.sum_ok); end
        n_cmp++; if (bus2.bus_err !== 1'b0) begin n_bad++; $display("FAIL reset bus_err: got %b want 0", bus2.bus_err); end
        n_cmp++; if (bus2.prom_ce_n !== 1'b1) begin n_bad++; $display("FAIL reset ce_n: got %b want 1", bus2.prom_ce_n); end
        n_cmp++; if (bus2.prom_a !== 5'd0) begin n_bad++; $display("FAIL reset prom_a: got %0d want 0", bus2.prom_a); end
        n_cmp++; if (bus4.prom_ce_n !== 1'b1) begin n_bad++; $display("FAIL reset ce_n4: got %b want 1", bus4.prom_ce_n); end
        for (int k = 0; k < 32; k += 7) begin
            bus2.rd_addr = 5'(k);
            #1;
            n_cmp++;
            if (bus2.rd_data !== 8'h00) begin
                n_bad++;
                $display("FAIL reset rd_data[%0d]: got %02h want 00", k, bus2.rd_data);
            end
        end
    endtask

    task automatic test_ramp();
        int fd, np;
        logic bd;
        load_ramp();
        bus2.exp_sum = 8'hF0;
        run_scan2(0, 0, fd, np, bd);
        n_cmp++; if (fd != LAT2) begin n_bad++; $display("FAIL ramp done_cycle: got %0d want %0d", fd, LAT2); end
        n_cmp++; if (np != 1) begin n_bad++; $display("FAIL ramp done_pulses: got %0d want 1", np); end
        n_cmp++; if (bd !== 1'b0) begin n_bad++; $display("FAIL ramp busy_at_done: got %b want 0", bd); end
        n_cmp++; if (bus2.img_valid !== 1'b1) begin n_bad++; $display("FAIL ramp img_valid: got %b want 1", bus2.img_valid); end
        n_cmp++; if (bus2.sum !== model_sum()) begin n_bad++; $display("FAIL ramp sum: got %02h want %02h", bus2.sum, model_sum()); end
        n_cmp++; if (bus2.sum_ok !== 1'b1) begin n_bad++; $display("FAIL ramp sum_ok: got %b want 1", bus2.sum_ok); end
        n_cmp++; if (bus2.bus_err !== 1'b0) begin n_bad++; $display("FAIL ramp bus_err: got %b want 0", bus2.bus_err); end
        check_image("ramp");
        bus2.exp_sum = 8'h00;
        #1;
        n_cmp++; if (bus2.sum_ok !== 1'b0) begin n_bad++; $display("FAIL badsum sum_ok: got %b want 0", bus2.sum_ok); end
        n_cmp++; if (bus2.img_valid !== 1'b1) begin n_bad++; $display("FAIL badsum img_valid: got %b want 1", bus2.img_valid); end
    endtask

    task automatic test_random();
        int fd, np;
        logic bd, want_ok;
        for (int r = 0; r < 3; r++) begin
            load_random();
            want_ok = 1'($urandom_range(1));
            bus2.exp_sum = want_ok ? model_sum() : model_sum() ^ 8'($urandom_range(255, 1));
            run_scan2(0, 0, fd, np, bd);
            n_cmp++; if (fd != LAT2) begin n_bad++; $display("FAIL rand done_cycle: got %0d want %0d", fd, LAT2); end
            n_cmp++; if (bus2.sum !== model_sum()) begin n_bad++; $display("FAIL rand sum: got %02h want %02h", bus2.sum, model_sum()); end
            n_cmp++; if (bus2.sum_ok !== want_ok) begin n_bad++; $display("FAIL rand sum_ok: got %b want %b", bus2.sum_ok, want_ok); end
            check_image("rand");
        end
    endtask

    task automatic test_float_err();
        int fd, np;
        logic bd;
        load_random();
        bus2.exp_sum = model_sum();
        float_bad = 1'b1;
        run_scan2(0, 0, fd, np, bd);
        float_bad = 1'b0;
        n_cmp++; if (bus2.bus_err !== 1'b1) begin n_bad++; $display("FAIL float bus_err: got %b want 1", bus2.bus_err); end
        n_cmp++; if (np != 1) begin n_bad++; $display("FAIL float done_pulses: got %0d want 1", np); end
        n_cmp++; if (bus2.sum_ok !== 1'b1) begin n_bad++; $display("FAIL float sum_ok: got %b want 1", bus2.sum_ok); end
        check_image("float");
        run_scan2(0, 0, fd, np, bd);
        n_cmp++; if (bus2.bus_err !== 1'b0) begin n_bad++; $display("FAIL float_clear bus_err: got %b want 0", bus2.bus_err); end
    endtask

    task automatic test_ignored_start();
        int fd, np, seen;
        logic bd;
        load_ramp();
        bus2.exp_sum = 8'hF0;
        run_scan2(5, 50, fd, np, bd);
        n_cmp++; if (fd != LAT2) begin n_bad++; $display("FAIL ign done_cycle: got %0d want %0d", fd, LAT2); end
        n_cmp++; if (np != 1) begin n_bad++; $display("FAIL ign done_pulses: got %0d want 1", np); end
        n_cmp++; if (bus2.sum !== 8'hF0) begin n_bad++; $display("FAIL ign sum: got %02h want f0", bus2.sum); end
        load_random();
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        n_cmp++; if (bus2.img_valid !== 1'b0) begin n_bad++; $display("FAIL rescan img_valid: got %b want 0", bus2.img_valid); end
        n_cmp++; if (bus2.busy !== 1'b1) begin n_bad++; $display("FAIL rescan busy: got %b want 1", bus2.busy); end
        seen = 0;
        for (int n = 0; n < LAT2 + 20 && seen == 0; n++) begin
            tick();
            if (bus2.done) seen = 1;
        end
        tick();
        n_cmp++; if (seen != 1) begin n_bad++; $display("FAIL rescan done_seen: got %0d want 1", seen); end
        n_cmp++; if (bus2.sum !== model_sum()) begin n_bad++; $display("FAIL rescan sum: got %02h want %02h", bus2.sum, model_sum()); end
    endtask

    task automatic test_reset_mid();
        int np;
        load_random();
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        // Byte 10 is captured on edge (S2+1)*12 after the start edge.
        for (int n = 1; n < (S2 + 1) * 12; n++) tick();
        n_cmp++; if (bus2.prom_a !== 5'd10) begin n_bad++; $display("FAIL mid prom_a: got %0d want 10", bus2.prom_a); end
        n_cmp++; if (bus2.prom_ce_n !== 1'b0) begin n_bad++; $display("FAIL mid ce_n: got %b want 0", bus2.prom_ce_n); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (bus2.busy !== 1'b0) begin n_bad++; $display("FAIL mid busy: got %b want 0", bus2.busy); end
        n_cmp++; if (bus2.sum !== 8'h00) begin n_bad++; $display("FAIL mid sum: got %02h want 00", bus2.sum); end
        n_cmp++; if (bus2.prom_ce_n !== 1'b1) begin n_bad++; $display("FAIL mid ce_n_after: got %b want 1", bus2.prom_ce_n); end
        n_cmp++; if (bus2.prom_a !== 5'd0) begin n_bad++; $display("FAIL mid prom_a_after: got %0d want 0", bus2.prom_a); end
        n_cmp++; if (bus2.img_valid !== 1'b0) begin n_bad++; $display("FAIL mid img_valid: got %b want 0", bus2.img_valid); end
        for (int k = 0; k < 10; k++) begin
            bus2.rd_addr = 5'(k);
            #1;
            n_cmp++;
            if (bus2.rd_data !== 8'h00) begin
                n_bad++;
                $display("FAIL mid shadow[%0d]: got %02h want 00", k, bus2.rd_data);
            end
        end
        np = 0;
        for (int n = 0; n < LAT2 + 20; n++) begin
            tick();
            if (bus2.done || bus2.busy) np++;
        end
        n_cmp++; if (np != 0) begin n_bad++; $display("FAIL mid no_resume: got %0d active cycles want 0", np); end
    endtask

    task automatic test_addr_seq();
        int run_a[$];
        int run_len[$];
        int fd, low_float, low_done, nlow;
        load_ramp();
        bus4.exp_sum = 8'hF0;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        fd = -1; low_float = 0; low_done = 0; nlow = 0;
        for (int n = 1; n <= LAT4 + 20; n++) begin
            if (!bus4.prom_ce_n) begin
                nlow++;
                if (n <= int'(S4) + 1) low_float++;
                if (run_a.size() == 0 || run_a[$] != int'(bus4.prom_a)) begin
                    run_a.push_back(int'(bus4.prom_a));
                    run_len.push_back(1);
                end else begin
                    run_len[$] = run_len[$] + 1;
                end
            end
            if (bus4.done && fd < 0) begin
                fd = n;
                if (!bus4.prom_ce_n) low_done++;
            end
            tick();
        end
        n_cmp++; if (fd != LAT4) begin n_bad++; $display("FAIL seq done_cycle: got %0d want %0d", fd, LAT4); end
        n_cmp++; if (low_float != 0) begin n_bad++; $display("FAIL seq ce_low_float: got %0d want 0", low_float); end
        n_cmp++; if (low_done != 0) begin n_bad++; $display("FAIL seq ce_low_done: got %0d want 0", low_done); end
        n_cmp++; if (nlow != 32 * (S4 + 1)) begin n_bad++; $display("FAIL seq ce_low_cycles: got %0d want %0d", nlow, 32 * (S4 + 1)); end
        n_cmp++; if (run_a.size() != 32) begin n_bad++; $display("FAIL seq runs: got %0d want 32", run_a.size()); end
        for (int k = 0; k < run_a.size() && k < 32; k++) begin
            n_cmp++;
            if (run_a[k] != k || run_len[k] != int'(S4) + 1) begin
                n_bad++;
                $display("FAIL seq run[%0d]: got addr %0d len %0d want addr %0d len %0d",
                         k, run_a[k], run_len[k], k, S4 + 1);
            end
        end
        n_cmp++; if (bus4.sum !== 8'hF0) begin n_bad++; $display("FAIL seq sum: got %02h want f0", bus4.sum); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_ramp();
        test_random();
        test_float_err();
        test_ignored_start();
        test_reset_mid();
        test_addr_seq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
